// File: rtl/decoder_result_arbiter_if.sv
// Bus bundle between the ITCH decoders (master) and the result arbiter (slave).
// It carries the per-source result pulses, the output stream and the drop reporting.
interface decoder_result_arbiter_if #(
    parameter int NUM_SRC   = 6,
    parameter int PAYLOAD_W = 192,
    parameter int SRC_ID_W  = 3
);
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC*PAYLOAD_W-1:0] src_payload;
    logic                         out_valid;
    logic                         out_ready;
    logic [SRC_ID_W-1:0]          out_src_id;
    logic [PAYLOAD_W-1:0]         out_payload;
    logic [NUM_SRC-1:0]           overflow;
    logic [15:0]                  drop_cnt;

    modport master (
        output src_valid, src_payload, out_ready,
        input  out_valid, out_src_id, out_payload, overflow, drop_cnt
    );

    modport slave (
        input  src_valid, src_payload, out_ready,
        output out_valid, out_src_id, out_payload, overflow, drop_cnt
    );
endinterface

// File: rtl/decoder_result_arbiter.sv
// Serializes one-cycle decoder result pulses through per-source 2-deep queues onto one
// registered valid/ready stream. Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module decoder_result_arbiter #(
    parameter int NUM_SRC   = 6,
    parameter int PAYLOAD_W = 192,
    parameter int SRC_ID_W  = 3
) (
    input logic                     clk,
    input logic                     rst,
    decoder_result_arbiter_if.slave arb_if
);
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } qstate_e;

    logic [NUM_SRC-1:0]   nonempty;
    logic [NUM_SRC-1:0]   pop;
    logic [NUM_SRC-1:0]   drop;
    logic [PAYLOAD_W-1:0] head_data [NUM_SRC];

    logic                 load;
    logic                 grant_found;
    logic [SRC_ID_W-1:0]  grant_idx;
    logic [PAYLOAD_W-1:0] grant_data;

    logic                 out_valid_q;
    logic [SRC_ID_W-1:0]  out_src_id_q;
    logic [PAYLOAD_W-1:0] out_payload_q;
    logic [NUM_SRC-1:0]   overflow_q;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    assign load = !out_valid_q || arb_if.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_queue
            logic [PAYLOAD_W-1:0] mem_q [2];
            logic                 wr_ptr_q, rd_ptr_q;
            qstate_e              state_q, state_d;
            logic                 push;

            // A FULL queue still accepts the push when its head leaves in the same cycle.
            assign push          = arb_if.src_valid[gi] && (state_q != Q_FULL || pop[gi]);
            assign drop[gi]      = arb_if.src_valid[gi] && (state_q == Q_FULL) && !pop[gi];
            assign nonempty[gi]  = (state_q != Q_EMPTY);
            assign pop[gi]       = load && grant_found && (grant_idx == SRC_ID_W'(gi));
            assign head_data[gi] = mem_q[rd_ptr_q];

            always_comb begin
                state_d = state_q;
                case ({push, pop[gi]})
                    2'b10:   state_d = (state_q == Q_EMPTY) ? Q_ONE : Q_FULL;
                    2'b01:   state_d = (state_q == Q_FULL) ? Q_ONE : Q_EMPTY;
                    default: state_d = state_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q  <= Q_EMPTY;
                    wr_ptr_q <= 1'b0;
                    rd_ptr_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    if (push)    wr_ptr_q <= ~wr_ptr_q;
                    if (pop[gi]) rd_ptr_q <= ~rd_ptr_q;
                end
            end

            always_ff @(posedge clk) begin
                if (push) mem_q[wr_ptr_q] <= arb_if.src_payload[gi*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    endgenerate

`ifdef ARB_FIXED_PRIORITY_EN
    // Descending scan so the lowest non-empty index is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (nonempty[k]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_ID_W'(k);
            end
        end
    end
`else
    logic [SRC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_ID_W:0]   cand;

    // Candidate offset k from rr_ptr; descending scan leaves the nearest one as winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (SRC_ID_W + 1)'(k);
            if (cand >= (SRC_ID_W + 1)'(NUM_SRC)) cand = cand - (SRC_ID_W + 1)'(NUM_SRC);
            if (nonempty[cand[SRC_ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_ID_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load && grant_found)
            rr_ptr_d = (grant_idx == SRC_ID_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_ID_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign grant_data = head_data[grant_idx];

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (drop[i] && drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_src_id_q  <= '0;
            out_payload_q <= '0;
            overflow_q    <= '0;
            drop_cnt_q    <= '0;
        end else begin
            overflow_q <= drop;
            drop_cnt_q <= drop_cnt_d;
            if (load) begin
                out_valid_q <= grant_found;
                if (grant_found) begin
                    out_src_id_q  <= grant_idx;
                    out_payload_q <= grant_data;
                end
            end
        end
    end

    assign arb_if.out_valid   = out_valid_q;
    assign arb_if.out_src_id  = out_src_id_q;
    assign arb_if.out_payload = out_payload_q;
    assign arb_if.overflow    = overflow_q;
    assign arb_if.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_decoder_result_arbiter.sv
// Testbench for decoder_result_arbiter: directed vector table, hand sequences for fairness
// and mid-stream reset, then random traffic checked against a queue-level reference model.
module tb_decoder_result_arbiter;
    localparam int NS = 6;
    localparam int PW = 192;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder_result_arbiter_if #(.NUM_SRC(NS), .PAYLOAD_W(PW), .SRC_ID_W(IW)) arb_if ();

    decoder_result_arbiter #(.NUM_SRC(NS), .PAYLOAD_W(PW), .SRC_ID_W(IW)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (arb_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain queues plus the output register contents.
    logic [PW-1:0] mq [NS][$];
    bit            m_valid;
    int            m_src;
    logic [PW-1:0] m_pay;
    logic [NS-1:0] m_ovf;
    int            m_drop;
    int            m_rr;

    function automatic logic [PW-1:0] make_pay(input int i, input logic [7:0] t);
        logic [PW-1:0] p;
        p            = '0;
        p[7:0]       = t;
        p[15:8]      = 8'(i);
        p[100 +: 8]  = t ^ 8'(i * 37);
        p[PW-1 -: 8] = ~t;
        return p;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input logic [NS-1:0] sv, input logic [7:0] tag, input bit rdy);
        int  g;
        int  c;
        bit  ld;
        if (r) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_valid = 0; m_src = 0; m_pay = '0; m_ovf = '0; m_drop = 0; m_rr = 0;
            return;
        end
        ld = !m_valid || rdy;
        g  = -1;
        if (ld) begin
            for (int k = 0; k < NS; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
                c = k;
`else
                c = (m_rr + k) % NS;
`endif
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                m_pay   = mq[g].pop_front();
                m_src   = g;
                m_valid = 1;
                m_rr    = (g + 1) % NS;
            end else begin
                m_valid = 0;
            end
        end
        m_ovf = '0;
        for (int i = 0; i < NS; i++) begin
            if (sv[i]) begin
                if (mq[i].size() < 2) mq[i].push_back(make_pay(i, tag));
                else begin
                    m_ovf[i] = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic drive(input bit r, input logic [NS-1:0] sv, input logic [7:0] tag, input bit rdy);
        rst              = r;
        arb_if.src_valid = sv;
        for (int i = 0; i < NS; i++) arb_if.src_payload[i*PW +: PW] = make_pay(i, tag);
        arb_if.out_ready = rdy;
        model_step(r, sv, tag, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input int cyc);
        chk($sformatf("rnd%0d.valid", cyc), arb_if.out_valid, m_valid);
        if (m_valid) begin
            chk($sformatf("rnd%0d.src", cyc), arb_if.out_src_id, m_src);
            chk($sformatf("rnd%0d.payload", cyc), arb_if.out_payload, m_pay);
        end
        chk($sformatf("rnd%0d.overflow", cyc), arb_if.overflow, m_ovf);
        chk($sformatf("rnd%0d.drop_cnt", cyc), arb_if.drop_cnt, m_drop);
    endtask

    typedef struct {
        bit            r;
        logic [NS-1:0] sv;
        logic [7:0]    tag;
        bit            rdy;
        bit            ev;
        int            es;
        logic [7:0]    et;
        logic [NS-1:0] eovf;
        int            edrop;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin
        // single result on src 3
        tbl[0]  = '{0, 6'b001000, 8'hAB, 1, 0, 0, 8'h00, 6'b000000, 0};
        tbl[1]  = '{0, 6'b000000, 8'h00, 1, 1, 3, 8'hAB, 6'b000000, 0};
        tbl[2]  = '{0, 6'b000000, 8'h00, 1, 0, 0, 8'h00, 6'b000000, 0};
        // simultaneous completion on src 0 and 2
        tbl[3]  = '{0, 6'b000101, 8'h11, 1, 0, 0, 8'h00, 6'b000000, 0};
        tbl[4]  = '{0, 6'b000000, 8'h00, 1, 1, 0, 8'h11, 6'b000000, 0};
        tbl[5]  = '{0, 6'b000000, 8'h00, 1, 1, 2, 8'h11, 6'b000000, 0};
        tbl[6]  = '{0, 6'b000000, 8'h00, 1, 0, 0, 8'h00, 6'b000000, 0};
        // backpressure on src 2: output holds 20, queue fills with 21/22, 23 dropped
        tbl[7]  = '{0, 6'b000100, 8'h20, 0, 0, 0, 8'h00, 6'b000000, 0};
        tbl[8]  = '{0, 6'b000000, 8'h00, 0, 1, 2, 8'h20, 6'b000000, 0};
        tbl[9]  = '{0, 6'b000100, 8'h21, 0, 1, 2, 8'h20, 6'b000000, 0};
        tbl[10] = '{0, 6'b000100, 8'h22, 0, 1, 2, 8'h20, 6'b000000, 0};
        tbl[11] = '{0, 6'b000100, 8'h23, 0, 1, 2, 8'h20, 6'b000100, 1};
        tbl[12] = '{0, 6'b000000, 8'h00, 0, 1, 2, 8'h20, 6'b000000, 1};
        tbl[13] = '{0, 6'b000000, 8'h00, 1, 1, 2, 8'h21, 6'b000000, 1};
        tbl[14] = '{0, 6'b000000, 8'h00, 1, 1, 2, 8'h22, 6'b000000, 1};
        tbl[15] = '{0, 6'b000000, 8'h00, 1, 0, 0, 8'h00, 6'b000000, 1};
        // push on full src 5 while its head is popped
        tbl[16] = '{0, 6'b100000, 8'h50, 0, 0, 0, 8'h00, 6'b000000, 1};
        tbl[17] = '{0, 6'b100000, 8'h51, 0, 1, 5, 8'h50, 6'b000000, 1};
        tbl[18] = '{0, 6'b100000, 8'h52, 0, 1, 5, 8'h50, 6'b000000, 1};
        tbl[19] = '{0, 6'b100000, 8'h53, 1, 1, 5, 8'h51, 6'b000000, 1};
        tbl[20] = '{0, 6'b000000, 8'h00, 0, 1, 5, 8'h51, 6'b000000, 1};
        tbl[21] = '{0, 6'b100000, 8'h54, 0, 1, 5, 8'h51, 6'b100000, 2};
        tbl[22] = '{0, 6'b000000, 8'h00, 1, 1, 5, 8'h52, 6'b000000, 2};
        tbl[23] = '{0, 6'b000000, 8'h00, 1, 1, 5, 8'h53, 6'b000000, 2};
        tbl[24] = '{0, 6'b000000, 8'h00, 1, 0, 0, 8'h00, 6'b000000, 2};

        arb_if.src_valid   = '0;
        arb_if.src_payload = '0;
        arb_if.out_ready   = 1'b0;

        drive(1, 6'b000000, 8'h00, 0);
        drive(1, 6'b111111, 8'h5A, 1);
        chk("reset.valid", arb_if.out_valid, 0);
        chk("reset.src", arb_if.out_src_id, 0);
        chk("reset.payload", arb_if.out_payload, 0);
        chk("reset.overflow", arb_if.overflow, 0);
        chk("reset.drop_cnt", arb_if.drop_cnt, 0);

        for (int v = 0; v < NV; v++) begin
            drive(tbl[v].r, tbl[v].sv, tbl[v].tag, tbl[v].rdy);
            $display("[TB] vec %0d sv=%b rdy=%0d -> valid=%0d src=%0d ovf=%b drop=%0d",
                     v, tbl[v].sv, tbl[v].rdy, arb_if.out_valid, arb_if.out_src_id,
                     arb_if.overflow, arb_if.drop_cnt);
            chk($sformatf("tbl%0d.valid", v), arb_if.out_valid, tbl[v].ev);
            if (tbl[v].ev) begin
                chk($sformatf("tbl%0d.src", v), arb_if.out_src_id, tbl[v].es);
                chk($sformatf("tbl%0d.payload", v), arb_if.out_payload, make_pay(tbl[v].es, tbl[v].et));
            end
            chk($sformatf("tbl%0d.overflow", v), arb_if.overflow, tbl[v].eovf);
            chk($sformatf("tbl%0d.drop_cnt", v), arb_if.drop_cnt, tbl[v].edrop);
        end

        // fairness: sources 1 and 4 pulse every cycle with the output always ready
        for (int c = 1; c <= 8; c++) begin
            drive(0, 6'b010010, 8'(8'h80 + c), 1);
            $display("[TB] fair %0d -> valid=%0d src=%0d ovf=%b", c, arb_if.out_valid,
                     arb_if.out_src_id, arb_if.overflow);
            if (c == 1) begin
                chk("fair.first_valid", arb_if.out_valid, 0);
            end else begin
                chk($sformatf("fair%0d.valid", c), arb_if.out_valid, 1);
`ifdef ARB_FIXED_PRIORITY_EN
                chk($sformatf("fair%0d.src", c), arb_if.out_src_id, 1);
                if (c >= 3) chk($sformatf("fair%0d.ovf4", c), arb_if.overflow[4], 1);
`else
                chk($sformatf("fair%0d.src", c), arb_if.out_src_id, (c % 2 == 0) ? 1 : 4);
`endif
            end
        end

        // reset mid-stream with queues non-empty and the output held
        drive(0, 6'b001001, 8'h70, 0);
        drive(0, 6'b001001, 8'h71, 0);
        chk("midrst.pre_valid", arb_if.out_valid, 1);
        drive(1, 6'b111111, 8'h72, 1);
        $display("[TB] midrst -> valid=%0d src=%0d drop=%0d", arb_if.out_valid,
                 arb_if.out_src_id, arb_if.drop_cnt);
        chk("midrst.valid", arb_if.out_valid, 0);
        chk("midrst.src", arb_if.out_src_id, 0);
        chk("midrst.payload", arb_if.out_payload, 0);
        chk("midrst.overflow", arb_if.overflow, 0);
        chk("midrst.drop_cnt", arb_if.drop_cnt, 0);
        for (int c = 0; c < 4; c++) begin
            drive(0, 6'b000000, 8'h00, 1);
            chk($sformatf("midrst.stale%0d", c), arb_if.out_valid, 0);
        end

        // random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            int            mode;
            bit            r;
            bit            rdy;
            logic [NS-1:0] sv;
            mode = (c / 200) % 3;
            r    = ($urandom_range(0, 399) == 0);
            case (mode)
                0: begin sv = NS'($urandom & $urandom); rdy = ($urandom_range(0, 3) != 0); end
                1: begin sv = NS'($urandom); rdy = ($urandom_range(0, 3) == 0); end
                default: begin sv = NS'($urandom & $urandom & $urandom); rdy = 1'b1; end
            endcase
            drive(r, sv, 8'($urandom), rdy);
            if (c % 250 == 0)
                $display("[TB] rnd %0d sv=%b rdy=%0d -> valid=%0d src=%0d drop=%0d",
                         c, sv, rdy, arb_if.out_valid, arb_if.out_src_id, arb_if.drop_cnt);
            cmp_model(c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
